axum_uart_loader: RTL

// Serial program loader: a second bus host beside the Ibex data port. Deserialises 8N1 bytes on a

---
 rtl/axum_uart_loader.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axum_uart_loader.sv
// Serial program loader: 8N1 UART receiver feeding a word-write command decoder
// that masters a simple req/gnt/rvalid bus and controls the core reset hold.
module axum_uart_loader #(
  parameter int unsigned ClksPerBit  = 434,
  parameter int unsigned TimeoutBits = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic        host_err_i,
  output logic        core_hold_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CntW      = $clog2(ClksPerBit);
  localparam int unsigned TmoCycles = TimeoutBits * ClksPerBit;
  localparam int unsigned TmoW      = $clog2(TmoCycles + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);
  localparam logic [TmoW-1:0] TmoLoad  = TmoW'(TmoCycles);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_REQ  = 3'd3;
  localparam logic [2:0] ST_RSP  = 3'd4;

  logic            rx_meta_q, rx_sync_q;
  logic [2:0]      rx_state_q, rx_state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            dly_pend_q, dly_pend_d;
  logic [CntW-1:0] dly_cnt_q, dly_cnt_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ferr_q, rx_ferr_d;

  logic [2:0]      st_q, st_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            req_d, hold_d, err_d;
  logic [31:0]     addr_d, wdata_d;

  // Two-flop synchroniser for the asynchronous RX pin (idles high)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next state; idle is only re-entered with the line high, so a low level there is a start edge.
  // The byte-valid pulse is delayed half a bit by a side counter so the receiver can catch the next start bit.
  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q + CntW'(1);
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    dly_pend_d = dly_pend_q;
    dly_cnt_d  = dly_cnt_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    if (dly_pend_q) begin
      if (dly_cnt_q == HalfLast) begin
        dly_pend_d = 1'b0;
        rx_valid_d = 1'b1;
      end else begin
        dly_cnt_d = dly_cnt_q + CntW'(1);
      end
    end
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
            dly_pend_d = 1'b1;
            dly_cnt_d  = CntW'(1);
          end else begin
            rx_state_d = RX_WAIT;
            rx_ferr_d  = 1'b1;
          end
        end
      end
      RX_WAIT: begin
        clk_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      dly_pend_q <= 1'b0;
      dly_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      dly_pend_q <= dly_pend_d;
      dly_cnt_q  <= dly_cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Frame decoder next state: commands, little-endian address/data assembly, inter-byte timeout, bus handshake
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    req_d   = host_req_o;
    addr_d  = host_addr_o;
    wdata_d = host_wdata_o;
    hold_d  = core_hold_o;
    err_d   = err_o;
    if (rx_ferr_q) err_d = 1'b1;
    case (st_q)
      ST_IDLE: begin
        if (rx_valid_q) begin
          case (shreg_q)
            8'hA5: begin
              st_d  = ST_ADDR;
              cnt_d = '0;
              tmo_d = TmoLoad;
            end
            8'h5A: hold_d = 1'b0;
            8'hC3: begin
              hold_d = 1'b1;
              err_d  = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_ADDR, ST_DATA: begin
        if (rx_valid_q) begin
          cnt_d = cnt_q + 2'd1;
          tmo_d = TmoLoad;
          if (st_q == ST_ADDR) begin
            addr_d[{cnt_q, 3'b000} +: 8] = shreg_q;
            if (cnt_q == 2'd3) st_d = ST_DATA;
          end else begin
            wdata_d[{cnt_q, 3'b000} +: 8] = shreg_q;
            if (cnt_q == 2'd3) begin
              addr_d[1:0] = 2'b00;
              req_d       = 1'b1;
              st_d        = ST_REQ;
            end
          end
        end else if (tmo_q == '0) begin
          st_d  = ST_IDLE;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TmoW'(1);
        end
      end
      ST_REQ: begin
        if (rx_valid_q) err_d = 1'b1;
        if (host_gnt_i) begin
          req_d = 1'b0;
          st_d  = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rx_valid_q) err_d = 1'b1;
        if (host_rvalid_i) begin
          if (host_err_i) err_d = 1'b1;
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Frame state and registered bus/control outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q         <= ST_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      host_req_o   <= 1'b0;
      host_addr_o  <= '0;
      host_wdata_o <= '0;
      host_we_o    <= 1'b0;
      host_be_o    <= 4'h0;
      core_hold_o  <= 1'b1;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      host_req_o   <= req_d;
      host_addr_o  <= addr_d;
      host_wdata_o <= wdata_d;
      host_we_o    <= req_d;
      host_be_o    <= req_d ? 4'hF : 4'h0;
      core_hold_o  <= hold_d;
      busy_o       <= (st_d != ST_IDLE);
      err_o        <= err_d;
    end
  end

endmodule
